// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared bus layouts, widths and encodings for the memory pipeline stage.
// Packed struct fields are listed MSB first, so each struct matches the
// flat bus vector that carries it.
package mem_stage_pkg;

  localparam int PB_W     = 16;
  localparam int ESUB_W   = 9;
  localparam int ECODE_W  = 8;
  localparam int CSRA_W   = 14;

  // Exception codes already in use elsewhere in the pipeline.
  localparam logic [ECODE_W-1:0] ECODE_ADE = 8'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE = 8'h09;

  // res_from_mem encodings: bit0 = is load, bit1 = half or wider,
  // bit2 = zero-extend, bit3 = full word.
  localparam logic [3:0] RFM_NONE  = 4'b0000;
  localparam logic [3:0] RFM_LD_B  = 4'b0001;
  localparam logic [3:0] RFM_LD_BU = 4'b0101;
  localparam logic [3:0] RFM_LD_H  = 4'b0011;
  localparam logic [3:0] RFM_LD_HU = 4'b0111;
  localparam logic [3:0] RFM_LD_W  = 4'b1011;

  typedef struct packed {
    logic [31:0]        rdata;
    logic [PB_W-1:0]    pb_bus;
    logic [31:0]        pc;
    logic [31:0]        alu_wdata;
    logic               gr_we;
    logic [4:0]         dest;
    logic [3:0]         res_from_mem;
    logic [31:0]        badvaddr;
    logic               ex;
    logic [ECODE_W-1:0] ecode;
    logic [ESUB_W-1:0]  esubcode;
    logic [CSRA_W-1:0]  csr_addr;
    logic               csr_we;
    logic [31:0]        csr_wmask;
    logic [31:0]        csr_wdata;
  } em_bus_t;

  typedef struct packed {
    logic [PB_W-1:0]    pb_bus;
    logic [31:0]        pc;
    logic [31:0]        rf_wdata;
    logic               gr_we;
    logic [4:0]         dest;
    logic               ex;
    logic [ECODE_W-1:0] ecode;
    logic [ESUB_W-1:0]  esubcode;
    logic [31:0]        badvaddr;
    logic [CSRA_W-1:0]  csr_addr;
    logic               csr_we;
    logic [31:0]        csr_wmask;
    logic [31:0]        csr_wdata;
  } mw_bus_t;

  typedef struct packed {
    logic               is_load;
    logic [4:0]         dest_masked;
    logic [31:0]        rf_wdata;
    logic               csr_we_valid;
    logic [CSRA_W-1:0]  csr_addr;
    logic [31:0]        csr_wmask;
    logic [31:0]        csr_wdata;
  } md_bus_t;

  localparam int EM_BUS_Wid     = $bits(em_bus_t);
  localparam int MW_BUS_Wid     = $bits(mw_bus_t);
  localparam int MD_for_BUS_Wid = $bits(md_bus_t);

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align
// Picks the addressed byte/halfword/word out of the returned load data and
// sign- or zero-extends it to 32 bits.
// Ports:
//   rdata        in  32  raw word returned by the data SRAM
//   addr         in   2  low address bits of the access
//   res_from_mem in   4  load type encoding (RFM_* in the package)
//   load_data    out 32  aligned, extended result (0 when not a load)
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  res_from_mem,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
  end

  assign w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  assign w_sext = !res_from_mem[2];

  always_comb begin
    load_data = '0;
    if (res_from_mem[0]) begin
      if (res_from_mem[3])
        load_data = rdata;
      else if (res_from_mem[1])
        load_data = {{16{w_sext & w_half[15]}}, w_half};
      else
        load_data = {{24{w_sext & w_byte[7]}}, w_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory pipeline stage: registers the execute-to-memory bus, aligns load
// data, forwards results/CSR writes to decode and hands exceptions on to
// writeback.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   W_allowin        writeback can accept this cycle
//   M_allowin        this stage can accept this cycle
//   EM_valid/EM_BUS  instruction offered by execute
//   MW_valid/MW_BUS  instruction offered to writeback
//   MD_for_BUS       forwarding info for decode
//   ex_M             held instruction carries an exception
//   ex_en            exception/ertn commit, flushes the stage
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      W_allowin,
  output logic                      M_allowin,
  input  logic                      EM_valid,
  input  logic [EM_BUS_Wid-1:0]     EM_BUS,
  output logic                      MW_valid,
  output logic [MW_BUS_Wid-1:0]     MW_BUS,
  output logic [MD_for_BUS_Wid-1:0] MD_for_BUS,
  output logic                      ex_M,
  input  logic                      ex_en
);

  em_bus_t     r_em_bus_m;
  logic        r_m_valid;
  logic        r_ex_flag;

  em_bus_t     w_em_in;
  logic        w_allowin;
  logic        w_ex_m;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;
  mw_bus_t     w_mw;
  md_bus_t     w_md;

  assign w_em_in   = em_bus_t'(EM_BUS);
  // M_ready_go is always 1, so the stage frees up whenever writeback takes it.
  assign w_allowin = !r_m_valid || W_allowin;
  assign w_ex_m    = r_m_valid && r_em_bus_m.ex;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_m_valid  <= 1'b0;
      r_em_bus_m <= '0;
      r_ex_flag  <= 1'b0;
    end else begin
      // Setting wins: a fault still held here must keep later instructions out.
      if (w_ex_m)
        r_ex_flag <= 1'b1;
      else if (ex_en)
        r_ex_flag <= 1'b0;

      if (ex_en) begin
        r_m_valid  <= 1'b0;
        r_em_bus_m <= '0;
      end else if (w_allowin) begin
        // Instructions behind a pending fault are consumed but never marked valid.
        r_m_valid <= EM_valid && !r_ex_flag;
        if (EM_valid)
          r_em_bus_m <= w_em_in;
      end
    end
  end

  load_align u_load_align (
    .rdata        (r_em_bus_m.rdata),
    .addr         (r_em_bus_m.badvaddr[1:0]),
    .res_from_mem (r_em_bus_m.res_from_mem),
    .load_data    (w_load_data)
  );

  // A faulting load never got valid data, so it reports the ALU result.
  assign w_rf_wdata = (r_em_bus_m.res_from_mem[0] && !r_em_bus_m.ex) ?
                      w_load_data : r_em_bus_m.alu_wdata;

  always_comb begin
    w_mw           = '0;
    w_mw.pb_bus    = r_em_bus_m.pb_bus;
    w_mw.pc        = r_em_bus_m.pc;
    w_mw.rf_wdata  = w_rf_wdata;
    w_mw.gr_we     = r_em_bus_m.gr_we && !r_em_bus_m.ex;
    w_mw.dest      = r_em_bus_m.dest;
    w_mw.ex        = r_em_bus_m.ex;
    w_mw.ecode     = r_em_bus_m.ecode;
    w_mw.esubcode  = r_em_bus_m.esubcode;
    w_mw.badvaddr  = r_em_bus_m.badvaddr;
    w_mw.csr_addr  = r_em_bus_m.csr_addr;
    w_mw.csr_we    = r_em_bus_m.csr_we && !r_em_bus_m.ex;
    w_mw.csr_wmask = r_em_bus_m.csr_wmask;
    w_mw.csr_wdata = r_em_bus_m.csr_wdata;
  end

  always_comb begin
    w_md              = '0;
    w_md.is_load      = r_m_valid && r_em_bus_m.res_from_mem[0];
    w_md.dest_masked  = r_em_bus_m.dest &
                        {5{r_m_valid && r_em_bus_m.gr_we && !r_em_bus_m.ex}};
    w_md.rf_wdata     = w_rf_wdata;
    w_md.csr_we_valid = r_m_valid && r_em_bus_m.csr_we && !r_em_bus_m.ex;
    w_md.csr_addr     = r_em_bus_m.csr_addr;
    w_md.csr_wmask    = r_em_bus_m.csr_wmask;
    w_md.csr_wdata    = r_em_bus_m.csr_wdata;
  end

  assign M_allowin  = w_allowin;
  assign MW_valid   = r_m_valid && !ex_en;
  assign ex_M       = w_ex_m;
  assign MW_BUS     = w_mw;
  assign MD_for_BUS = w_md;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int EM_W = mem_stage_pkg::EM_BUS_Wid;
  localparam int MW_W = mem_stage_pkg::MW_BUS_Wid;
  localparam int MD_W = mem_stage_pkg::MD_for_BUS_Wid;
  localparam int PB_W = mem_stage_pkg::PB_W;

  // MW_BUS field positions
  localparam int MW_PC_L  = MW_W - PB_W - 32;
  localparam int MW_RF_L  = MW_W - PB_W - 64;
  localparam int MW_GRWE  = MW_W - PB_W - 65;
  localparam int MW_DST_L = MW_W - PB_W - 70;
  localparam int MW_CSRWE = 64;
  // MD_for_BUS field positions
  localparam int MD_LOAD  = MD_W - 1;
  localparam int MD_DST_L = MD_W - 6;
  localparam int MD_CSRV  = 78;
  localparam int MD_CSRA_L = 64;

  typedef struct packed {
    logic [31:0]     rdata;
    logic [PB_W-1:0] pb;
    logic [31:0]     pc;
    logic [31:0]     alu;
    logic            gr_we;
    logic [4:0]      dest;
    logic [3:0]      rfm;
    logic [31:0]     badv;
    logic            ex;
    logic [7:0]      ecode;
    logic [8:0]      esub;
    logic [13:0]     csr_addr;
    logic            csr_we;
    logic [31:0]     wmask;
    logic [31:0]     wdata;
  } rec_t;

  logic clk = 1'b0;
  logic rstn, W_allowin, EM_valid, ex_en;
  logic M_allowin, MW_valid, ex_M;
  logic [EM_W-1:0] EM_BUS;
  logic [MW_W-1:0] MW_BUS;
  logic [MD_W-1:0] MD_for_BUS;
  rec_t drv;

  int tests = 0;
  int fails = 0;
  bit started = 0;
  bit log_en = 0;
  logic [31:0] dep_pc[$];

  always #5 clk = ~clk;

  function automatic logic [EM_W-1:0] pack_em(input rec_t r);
    return {r.rdata, r.pb, r.pc, r.alu, r.gr_we, r.dest, r.rfm, r.badv,
            r.ex, r.ecode, r.esub, r.csr_addr, r.csr_we, r.wmask, r.wdata};
  endfunction

  assign EM_BUS = pack_em(drv);

  mem_stage dut (
    .clk(clk), .rstn(rstn), .W_allowin(W_allowin), .M_allowin(M_allowin),
    .EM_valid(EM_valid), .EM_BUS(EM_BUS), .MW_valid(MW_valid), .MW_BUS(MW_BUS),
    .MD_for_BUS(MD_for_BUS), .ex_M(ex_M), .ex_en(ex_en)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   m_valid, m_flag;
  rec_t m_rec;

  function automatic logic [31:0] exp_rf(input rec_t r);
    logic [31:0] v;
    int a;
    a = int'(r.badv[1:0]);
    if (r.ex || !r.rfm[0]) return r.alu;
    if (r.rfm == 4'b1011) return r.rdata;
    if (r.rfm[1]) begin
      v = (r.rdata >> ((a / 2) * 16)) & 32'h0000FFFF;
      if (!r.rfm[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = (r.rdata >> (a * 8)) & 32'h000000FF;
      if (!r.rfm[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    bit allow, had_ex;
    if (!rstn) begin
      m_valid = 0; m_flag = 0; m_rec = '0;
    end else begin
      had_ex = m_valid && m_rec.ex;
      allow  = !m_valid || W_allowin;
      if (ex_en) begin
        m_valid = 0; m_rec = '0;
      end else if (allow) begin
        m_valid = EM_valid && !m_flag;
        if (EM_valid) m_rec = drv;
      end
      if (had_ex) m_flag = 1;
      else if (ex_en) m_flag = 0;
    end
  end

  always @(negedge clk) begin
    logic [MW_W-1:0] e_mw;
    logic [MD_W-1:0] e_md;
    logic [31:0] rf;
    if (started) begin
      rf = exp_rf(m_rec);
      e_mw = {m_rec.pb, m_rec.pc, rf, m_rec.gr_we & ~m_rec.ex, m_rec.dest, m_rec.ex,
              m_rec.ecode, m_rec.esub, m_rec.badv, m_rec.csr_addr,
              m_rec.csr_we & ~m_rec.ex, m_rec.wmask, m_rec.wdata};
      e_md = {m_valid & m_rec.rfm[0],
              m_rec.dest & {5{m_valid & m_rec.gr_we & ~m_rec.ex}}, rf,
              m_valid & m_rec.csr_we & ~m_rec.ex, m_rec.csr_addr, m_rec.wmask, m_rec.wdata};
      chk("M_allowin", M_allowin, !m_valid || W_allowin);
      chk("MW_valid", MW_valid, m_valid && !ex_en);
      chk("ex_M", ex_M, m_valid && m_rec.ex);
      chk("MW_BUS", MW_BUS, e_mw);
      chk("MD_for_BUS", MD_for_BUS, e_md);
      if (log_en && MW_valid && W_allowin) dep_pc.push_back(MW_BUS[MW_PC_L +: 32]);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic rec_t mk(input logic [31:0] pc, input logic [3:0] rfm,
                              input logic [31:0] rdata, input logic [1:0] a,
                              input logic [4:0] dest);
    rec_t r;
    r = '0;
    r.pc = pc; r.rfm = rfm; r.rdata = rdata; r.dest = dest; r.gr_we = 1'b1;
    r.badv = {28'h0001000, 2'b00, a};
    r.alu = pc ^ 32'h5555_0000;
    r.pb = pc[15:0] ^ 16'hA5A5;
    r.wmask = 32'h0000_00FF;
    r.wdata = pc + 32'h1;
    return r;
  endfunction

  task automatic step(input bit v, input bit e);
    EM_valid = v; ex_en = e;
    @(posedge clk); #1;
    EM_valid = 0; ex_en = 0;
  endtask

  task automatic send(input rec_t r);
    bit acc;
    drv = r; EM_valid = 1;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk); acc = M_allowin;
      @(posedge clk); #1;
    end
    if (!acc) begin
      fails++; tests++;
      $display("FAIL send_timeout actual=stalled expected=accepted");
    end
  endtask

  initial begin
    rec_t r;
    rstn = 0; W_allowin = 1; EM_valid = 0; ex_en = 0; drv = '0;
    @(posedge clk); started = 1;
    @(posedge clk); #1;
    rstn = 1;
    chk("rst_allowin", M_allowin, 1'b1);
    chk("rst_mw_valid", MW_valid, 1'b0);
    chk("rst_ex_M", ex_M, 1'b0);
    chk("rst_mw_bus", MW_BUS, '0);
    chk("rst_md_bus", MD_for_BUS, '0);

    // loads
    drv = mk(32'h1000, 4'b0001, 32'h8899AABB, 2'd2, 5'd5); step(1, 0);
    chk("ldb_valid", MW_valid, 1'b1);
    chk("ldb_rf", MW_BUS[MW_RF_L +: 32], 32'hFFFFFF99);
    chk("ldb_grwe", MW_BUS[MW_GRWE], 1'b1);
    chk("ldb_dest", MW_BUS[MW_DST_L +: 5], 5'd5);
    drv = mk(32'h1004, 4'b0101, 32'h8899AABB, 2'd2, 5'd5); step(1, 0);
    chk("ldbu_rf", MW_BUS[MW_RF_L +: 32], 32'h00000099);
    drv = mk(32'h1008, 4'b0111, 32'h8899AABB, 2'd2, 5'd6); step(1, 0);
    chk("ldhu_rf", MW_BUS[MW_RF_L +: 32], 32'h00008899);
    drv = mk(32'h100C, 4'b0011, 32'h8899AABB, 2'd0, 5'd6); step(1, 0);
    chk("ldh_rf", MW_BUS[MW_RF_L +: 32], 32'hFFFFAABB);
    drv = mk(32'h1010, 4'b1011, 32'h8899AABB, 2'd0, 5'd7); step(1, 0);
    chk("ldw_rf", MW_BUS[MW_RF_L +: 32], 32'h8899AABB);
    chk("ldw_is_load", MD_for_BUS[MD_LOAD], 1'b1);
    step(0, 0);

    // stream with a 3-cycle writeback stall
    log_en = 1;
    fork
      begin
        for (int i = 0; i < 4; i++) send(mk(32'h100 + 32'(4 * i), 4'b0000, 32'h0, 2'd0, 5'(i + 1)));
        EM_valid = 0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 W_allowin = 0;
        repeat (3) begin
          @(negedge clk); chk("stall_allowin", M_allowin, 1'b0);
          @(posedge clk); #1;
        end
        W_allowin = 1;
      end
    join
    repeat (3) @(posedge clk);
    #1 log_en = 0;
    chk("stream_count", dep_pc.size(), 4);
    for (int i = 0; i < 4 && i < dep_pc.size(); i++)
      chk("stream_pc", dep_pc[i], 32'h100 + 32'(4 * i));

    // exception
    r = mk(32'h200, 4'b0000, 32'h0, 2'd1, 5'd7);
    r.ex = 1; r.ecode = 8'h09; r.csr_we = 1; r.csr_addr = 14'h006;
    drv = r; step(1, 0);
    chk("exc_ex_M", ex_M, 1'b1);
    chk("exc_valid", MW_valid, 1'b1);
    chk("exc_grwe", MW_BUS[MW_GRWE], 1'b0);
    chk("exc_csrwe", MW_BUS[MW_CSRWE], 1'b0);
    chk("exc_md_dest", MD_for_BUS[MD_DST_L +: 5], 5'd0);
    chk("exc_md_csrv", MD_for_BUS[MD_CSRV], 1'b0);
    step(0, 0);
    drv = mk(32'h204, 4'b0000, 32'h0, 2'd0, 5'd8); step(1, 0);
    chk("drop1_valid", MW_valid, 1'b0);
    drv = mk(32'h208, 4'b0000, 32'h0, 2'd0, 5'd9); step(1, 0);
    chk("drop2_valid", MW_valid, 1'b0);
    step(0, 1);
    drv = mk(32'h300, 4'b0000, 32'h0, 2'd0, 5'd10); step(1, 0);
    chk("after_ex_valid", MW_valid, 1'b1);
    chk("after_ex_pc", MW_BUS[MW_PC_L +: 32], 32'h300);

    // flush together with an offer
    drv = mk(32'h400, 4'b0000, 32'h0, 2'd0, 5'd11); step(1, 1);
    chk("flush_valid", MW_valid, 1'b0);
    chk("flush_allowin", M_allowin, 1'b1);

    // reset while holding a load under stall
    W_allowin = 0;
    drv = mk(32'h500, 4'b1011, 32'h12345678, 2'd0, 5'd12); step(1, 0);
    chk("hold_load_valid", MW_valid, 1'b1);
    rstn = 0; @(posedge clk); #1; rstn = 1;
    chk("rst_mid_valid", MW_valid, 1'b0);
    chk("rst_mid_allowin", M_allowin, 1'b1);

    // CSR forwarding while held
    r = mk(32'h600, 4'b0000, 32'h0, 2'd0, 5'd0);
    r.csr_we = 1; r.csr_addr = 14'h006;
    drv = r; step(1, 0);
    step(0, 0);
    chk("fwd_csrv", MD_for_BUS[MD_CSRV], 1'b1);
    chk("fwd_csra", MD_for_BUS[MD_CSRA_L +: 14], 14'h006);
    chk("fwd_hold_allowin", M_allowin, 1'b0);
    W_allowin = 1;
    step(0, 0);
    step(0, 0);

    started = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory (M) pipeline stage. Sits between the execute stage and writeback. It registers the execute-to-memory bus and aligns and extends load data returned with it. It forwards results and pending CSR writes back to decode, and passes exceptions and the PB branch-record fields on to writeback. The execute stage already waits for `data_sram_data_ok` before handing over, so this stage has no SRAM port of its own.

## Interface
Parameters:
- none. Bus widths `EM_BUS_Wid`, `MW_BUS_Wid`, `MD_for_BUS_Wid` and `WpD_BUS_Wid` come from `Defines.vh`.

Ports:
- `clk`  in  1  clock; the block uses one clock.
- `rstn`  in  1  reset; synchronous and active-low.
- `W_allowin`  in  1  writeback can accept an instruction this cycle.
- `M_allowin`  out  1  this stage can accept an instruction this cycle.
- `EM_valid`  in  1  execute is offering an instruction.
- `EM_BUS`  in  `EM_BUS_Wid`  execute-to-memory bus, fields listed under Operation.
- `MW_valid`  out  1  this stage is offering an instruction to writeback.
- `MW_BUS`  out  `MW_BUS_Wid`  memory-to-writeback bus, fields in this order: PB_BUS, pc, rf_wdata, gr_we, dest, ex, ecode, esubcode, badvaddr, csr_addr, csr_we, csr_wmask, csr_wdata.
- `MD_for_BUS`  out  `MD_for_BUS_Wid`  forwarding bus to decode: {is_load, dest_masked, rf_wdata, csr_we_valid, csr_addr, csr_wmask, csr_wdata}.
- `ex_M`  out  1  the instruction held here carries an exception.
- `ex_en`  in  1  exception or ertn commit; flushes the stage.

## Operation
EM_BUS fields, MSB to LSB:
- rdata[31:0], PB_BUS, pc, alu_wdata.
- gr_we, dest[4:0], res_from_mem[3:0], badvaddr.
- ex, ecode[7:0], esubcode.
- csr_addr[13:0], csr_we, csr_wmask, csr_wdata.

Pipeline register `EM_BUS_M` and valid bit `M_valid`:
- `M_ready_go` = 1.
- `M_allowin` = !M_valid || W_allowin.
- `MW_valid` = M_valid && !ex_en.
- Load when `EM_valid && M_allowin`.
- `M_valid` <= `EM_valid && !ex_flag` whenever `M_allowin`.

res_from_mem encoding:
- 0000: not a load.
- 0001: ld.b.
- 0101: ld.bu.
- 0011: ld.h.
- 0111: ld.hu.
- 1011: ld.w.
- Bit 0 means "is load"; bit 2 means zero-extend.

Load alignment uses `badvaddr[1:0]`, which holds the vaddr for memory operations:
- Byte load: lane = rdata[8*a+7 : 8*a], where a = badvaddr[1:0].
- Halfword load: lane = rdata[31:16] when a[1] = 1, otherwise rdata[15:0].
- Word load: rdata unchanged.
- Result is sign- or zero-extended to 32 bits according to bit 2.
- `rf_wdata` = load result if bit 0 is set, otherwise alu_wdata.

Exceptions:
- `ex_M` = M_valid && ex.
- `ex_flag` is set when `ex_M` is asserted and cleared on `ex_en`. Set has priority if both occur in the same cycle.
- While `ex_flag` is set, incoming instructions are taken off the bus and dropped (`M_valid` stays 0).
- A faulting instruction passes on with `gr_we` forced to 0 and `csr_we` forced to 0 in MW_BUS. Its `rf_wdata` is alu_wdata; no load extraction is applied.

Flush:
- On `ex_en`: `M_valid` <= 0 and `EM_BUS_M` <= 0, taking priority over any load in the same cycle.
- `ex_flag` follows the set/clear rule above.

Forwarding fields:
- `dest_masked` = dest & {5{M_valid && gr_we && !ex}}.
- `csr_we_valid` = M_valid && csr_we && !ex.
- `is_load` = M_valid && res_from_mem[0].

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is offered on `MW_valid` from cycle N+1.
- Throughput is one instruction per cycle when `W_allowin` = 1.
- When `W_allowin` = 0, `EM_BUS_M` and `M_valid` hold and all outputs stay stable.
- Accept and departure in the same cycle are allowed; there is no bubble.
- Reset values: `M_valid` = 0, `EM_BUS_M` = 0, `ex_flag` = 0.
- Outputs after reset: `M_allowin` = 1, `MW_valid` = 0, `ex_M` = 0, `MD_for_BUS` = 0 (all fields from the zeroed register), `MW_BUS` = 0.
- Reset mid-operation discards the held instruction at the next edge.
- `MW_valid` is combinationally masked by `ex_en` in the same cycle.

## Structure
- Field offsets and width macros for EM_BUS, MW_BUS and MD_for_BUS live in `Defines.vh`, next to the existing ECODE defines.
- The res_from_mem encodings are added to `Defines.vh` as named constants.
- One sub-module, `load_align`: purely combinational, with inputs rdata, addr[1:0] and res_from_mem, producing a 32-bit output.
- Handshake, register, flush and forwarding logic stay in `mem_stage`.

## Test plan
- ld.b, rdata=0x8899AABB, badvaddr[1:0]=2, gr_we=1, dest=5 → MW_BUS rf_wdata=0xFFFFFF99, gr_we=1, dest=5. Same with ld.bu → 0x00000099.
- ld.hu, rdata=0x8899AABB, a=2 → 0x00008899. ld.h, a=0 → 0xFFFFAABB. ld.w → 0x8899AABB.
- Back-to-back stream of 4 ALU instructions with W_allowin=1 → MW_valid high 4 consecutive cycles, pc order preserved. W_allowin=0 for 3 cycles mid-stream → MW_BUS held, M_allowin=0, no loss or duplication.
- Instruction with ex=1, ecode=ALE, csr_we=1 arrives → ex_M=1, MW_BUS gr_we=0, csr_we=0, MD_for_BUS dest_masked=0. Next 2 EM_valid instructions are dropped until ex_en is pulsed; instruction after ex_en passes.
- ex_en and EM_valid asserted together → M_valid=0 next cycle. Reset asserted while holding a valid load → MW_valid=0, M_allowin=1 after the edge.
- Forwarding: csr_we=1 with csr_addr=0x006 held → MD_for_BUS csr_we_valid=1, csr_addr=0x006. Load held → is_load=1.
